// File: rtl/uart_rx_byte_if.sv
// Handshake and serial-line bundle between the UART byte receiver and its
// consumer (the configuration register bank).
interface uart_rx_byte_if;
  logic       rx_in;
  logic       ack_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       frame_err_out;
  logic       overrun_out;
  logic       busy_out;

  modport master (
    output rx_in, ack_in,
    input  data_out, valid_out, frame_err_out, overrun_out, busy_out
  );

  modport slave (
    input  rx_in, ack_in,
    output data_out, valid_out, frame_err_out, overrun_out, busy_out
  );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver, LSB first, idle-high line; delivers bytes on a
// valid/ack handshake and pulses on framing errors and overruns.
module uart_rx_byte #(
  parameter int unsigned CLKS_PER_BIT = 142,
  parameter int unsigned HALF_BIT     = (CLKS_PER_BIT - 1) / 2
) (
  input logic           clk_in,
  input logic           rst_in,
  uart_rx_byte_if.slave bus
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_C = CW'(HALF_BIT);
  localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          rx_meta_q, rx_s_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      rx_meta_q <= bus.rx_in;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    // A completing byte below overrides this clear, so ack and load in the
    // same cycle leave valid set without an overrun.
    if (valid_q && bus.ack_in) valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_C) begin
          cnt_d = '0;
          idx_d = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      S_DATA: begin
        if (cnt_q == LAST_C) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      S_STOP: begin
        if (cnt_q == LAST_C) begin
          cnt_d = '0;
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            ovr_d   = valid_q && !bus.ack_in;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      S_WAIT_HIGH: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.data_out      = data_q;
  assign bus.valid_out     = valid_q;
  assign bus.frame_err_out = ferr_q;
  assign bus.overrun_out   = ovr_q;
  assign bus.busy_out      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte: table of frames, hand-written corner
// sequences and random frames checked against a frame-level scoreboard.
module tb_uart_rx_byte;
  localparam int unsigned CPB  = 142;
  localparam int unsigned HALF = (CPB - 1) / 2;
  localparam int          LAT  = 9 * CPB + HALF + 4;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  uart_rx_byte_if bus();

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: records byte-load events and frame-error pulses at mid-cycle.
  typedef struct { int cyc; logic [7:0] data; logic ovr; } ev_t;
  ev_t ev_q[$];
  int  ferr_q[$];
  int  busy_run = 0;
  int  last_busy_run = 0;
  int  ack_viol = 0;
  bit  prev_valid = 0;
  bit  prev_ackv = 0;

  always @(negedge clk_in) begin
    if (rst_in) begin
      prev_valid = 0;
      prev_ackv  = 0;
    end else begin
      if ((bus.valid_out && !prev_valid) || bus.overrun_out)
        ev_q.push_back('{cyc, bus.data_out, bus.overrun_out});
      if (bus.frame_err_out) ferr_q.push_back(cyc);
      if (prev_ackv && bus.valid_out) ack_viol++;
      prev_ackv  = bus.ack_in && bus.valid_out;
      prev_valid = bus.valid_out;
    end
    if (bus.busy_out) busy_run++;
    else begin
      if (busy_run != 0) last_busy_run = busy_run;
      busy_run = 0;
    end
  end

  // Consumer model: acknowledges ack_delay cycles after it sees valid_out.
  bit auto_ack = 0;
  int ack_delay = 0;
  int wcnt = -1;
  initial begin
    bus.ack_in = 1'b0;
    forever begin
      @(posedge clk_in); #1;
      bus.ack_in = 1'b0;
      if (!auto_ack || !bus.valid_out) wcnt = -1;
      else if (wcnt < 0) wcnt = ack_delay;
      else if (wcnt == 0) begin
        bus.ack_in = 1'b1;
        wcnt = -1;
      end else wcnt--;
    end
  end

  // Frame-level reference: each good frame loads its byte LAT clocks after
  // its start edge; it overruns iff the previous byte is still unacknowledged.
  typedef struct { int fall; logic [7:0] data; logic ovr; } exp_t;
  exp_t       exp_q[$];
  int         exp_ferr_q[$];
  logic [7:0] m_data = 8'h00;
  bit         m_pend = 0;
  bit         busy_at_release = 0;

  task automatic step();
    @(posedge clk_in); #1;
  endtask

  task automatic idle(input int n);
    bus.rx_in = 1'b1;
    repeat (n) step();
  endtask

  task automatic set_ack(input bit en, input int dly);
    auto_ack  = en;
    ack_delay = dly;
    if (en) m_pend = 0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int hold, output int fall);
    fall = cyc;
    bus.rx_in = 1'b0;
    repeat (CPB) step();
    for (int i = 0; i < 8; i++) begin
      bus.rx_in = d[i];
      repeat (CPB) step();
    end
    bus.rx_in = stop;
    repeat (CPB) step();
    if (!stop) begin
      repeat (hold) step();
      busy_at_release = bus.busy_out;
      bus.rx_in = 1'b1;
    end
  endtask

  task automatic frame(input logic [7:0] d, input logic stop, input int hold);
    int fall;
    send_frame(d, stop, hold, fall);
    if (stop) begin
      exp_q.push_back('{fall, d, m_pend});
      m_data = d;
      m_pend = !auto_ack;
    end else begin
      exp_ferr_q.push_back(fall);
    end
  endtask

  task automatic clear_logs();
    ev_q.delete();
    ferr_q.delete();
    exp_q.delete();
    exp_ferr_q.delete();
  endtask

  task automatic drain(input string tag);
    ev_t  e;
    exp_t x;
    int   lat;
    idle(100);
    check($sformatf("%s load count", tag), ev_q.size(), exp_q.size());
    while (ev_q.size() != 0 && exp_q.size() != 0) begin
      e = ev_q.pop_front();
      x = exp_q.pop_front();
      lat = e.cyc - x.fall;
      check($sformatf("%s data", tag), e.data, x.data);
      check($sformatf("%s overrun", tag), e.ovr, x.ovr);
      check($sformatf("%s latency %0d", tag, lat), (lat >= LAT - 2 && lat <= LAT + 2), 1);
    end
    check($sformatf("%s frame_err count", tag), ferr_q.size(), exp_ferr_q.size());
    while (ferr_q.size() != 0 && exp_ferr_q.size() != 0) begin
      lat = ferr_q.pop_front() - exp_ferr_q.pop_front();
      check($sformatf("%s frame_err latency %0d", tag, lat), (lat >= LAT - 2 && lat <= LAT + 2), 1);
    end
    check($sformatf("%s data_out", tag), bus.data_out, m_data);
    check($sformatf("%s valid_out", tag), bus.valid_out, m_pend);
    check($sformatf("%s busy_out idle", tag), bus.busy_out, 0);
    clear_logs();
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s data_out", tag), bus.data_out, 8'h00);
    check($sformatf("%s valid_out", tag), bus.valid_out, 0);
    check($sformatf("%s frame_err_out", tag), bus.frame_err_out, 0);
    check($sformatf("%s overrun_out", tag), bus.overrun_out, 0);
    check($sformatf("%s busy_out", tag), bus.busy_out, 0);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         hold;
    bit         ack;
    logic [7:0] exp_data;
    logic       exp_valid;
    int         exp_ferr;
    int         exp_ovr;
  } vec_t;

  initial begin
    vec_t vecs[7];
    int   novr;
    logic [7:0] rd;
    logic rs;

    vecs[0] = '{8'hA5, 1'b1, 0,  1'b1, 8'hA5, 1'b0, 0, 0};
    vecs[1] = '{8'h5A, 1'b1, 0,  1'b0, 8'h5A, 1'b1, 0, 0};
    vecs[2] = '{8'h0F, 1'b0, 20, 1'b0, 8'h5A, 1'b1, 1, 0};
    vecs[3] = '{8'hF0, 1'b1, 0,  1'b0, 8'hF0, 1'b1, 0, 1};
    vecs[4] = '{8'hC3, 1'b1, 0,  1'b1, 8'hC3, 1'b0, 0, 0};
    vecs[5] = '{8'h00, 1'b1, 0,  1'b1, 8'h00, 1'b0, 0, 0};
    vecs[6] = '{8'hFF, 1'b0, 0,  1'b1, 8'h00, 1'b0, 1, 0};

    bus.rx_in = 1'b1;
    rst_in = 1'b1;
    repeat (3) step();
    check_reset_outputs("reset");
    rst_in = 1'b0;
    idle(20);

    // Table-driven frames.
    for (int i = 0; i < 7; i++) begin
      set_ack(vecs[i].ack, 10);
      frame(vecs[i].d, vecs[i].stop, vecs[i].hold);
      idle(100);
      novr = 0;
      foreach (ev_q[k]) if (ev_q[k].ovr) novr++;
      check($sformatf("vec%0d frame_err pulses", i), ferr_q.size(), vecs[i].exp_ferr);
      check($sformatf("vec%0d overrun pulses", i), novr, vecs[i].exp_ovr);
      check($sformatf("vec%0d data_out", i), bus.data_out, vecs[i].exp_data);
      check($sformatf("vec%0d valid_out", i), bus.valid_out, vecs[i].exp_valid);
      drain($sformatf("vec%0d", i));
    end

    // Short low glitch is rejected at the half-bit check.
    set_ack(1, 5);
    last_busy_run = 0;
    bus.rx_in = 1'b0;
    repeat (30) step();
    idle(150);
    check($sformatf("glitch busy run %0d", last_busy_run),
          (last_busy_run >= HALF - 1 && last_busy_run <= HALF + 3), 1);
    drain("glitch");

    // Break: stop bit low and line held low, then a good byte.
    frame(8'h3C, 1'b0, 400);
    check("break busy while low", busy_at_release, 1);
    idle(50);
    frame(8'h81, 1'b1, 0);
    drain("break");

    // Overrun: two bytes without ack.
    set_ack(0, 0);
    frame(8'h11, 1'b1, 0);
    idle(30);
    frame(8'h22, 1'b1, 0);
    drain("overrun");

    // Back-to-back frames with zero idle bits, acked on arrival.
    set_ack(1, 0);
    frame(8'h00, 1'b1, 0);
    frame(8'hFF, 1'b1, 0);
    drain("b2b");

    // Reset in the middle of DATA of 0x5A with an unacked byte pending.
    set_ack(0, 0);
    frame(8'h77, 1'b1, 0);
    drain("pre-reset");
    rd = 8'h5A;
    bus.rx_in = 1'b0;
    repeat (CPB) step();
    for (int i = 0; i < 4; i++) begin
      bus.rx_in = rd[i];
      repeat (CPB) step();
    end
    rst_in = 1'b1;
    bus.rx_in = 1'b1;
    step();
    check_reset_outputs("mid-frame reset");
    repeat (3) step();
    rst_in = 1'b0;
    m_data = 8'h00;
    m_pend = 0;
    clear_logs();
    idle(2 * CPB);
    check("after reset no load", ev_q.size(), 0);
    set_ack(1, 3);
    frame(8'hC3, 1'b1, 0);
    drain("post-reset");

    // Random frames against the scoreboard.
    rs = 1'b1;
    for (int i = 0; i < 14; i++) begin
      set_ack($urandom_range(1, 0) != 0, $urandom_range(30, 0));
      rd = 8'($urandom);
      rs = ($urandom_range(5, 0) != 0);
      frame(rd, rs, $urandom_range(50, 0));
      idle(rs ? $urandom_range(150, 0) : $urandom_range(150, 10));
      if (i % 7 == 6) drain($sformatf("rand%0d", i));
    end

    check("ack clears valid next cycle", ack_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- UART byte receiver that deserialises the configuration line ahead of the register bank.
- Format is 8N1, LSB first, idle-high line.
- Delivers each received byte with a valid/ack handshake, and flags framing errors and overruns.
- The register bank consumes data_out to write its fields (enable, n_sat, noise/signal off, ca_phase, doppler, snr).

Parameters:
- CLKS_PER_BIT, 142: clk_in cycles per UART bit. Minimum 4.
- HALF_BIT, (CLKS_PER_BIT-1)/2: counter value at which the start bit is validated (70 for the default).

Ports:
- clk_in  input  1  system clock; all logic on the rising edge.
- rst_in  input  1  synchronous, active-high reset.
- rx_in  input  1  asynchronous serial line; idles high.
- ack_in  input  1  consumer acknowledge; clears valid_out.
- data_out  output  8  last received byte.
- valid_out  output  1  data_out holds an unacknowledged byte.
- frame_err_out  output  1  one-cycle pulse when the stop bit is sampled low.
- overrun_out  output  1  one-cycle pulse when a byte is overwritten before ack.
- busy_out  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst_in high at a clk_in edge):
  - state=IDLE; bit counter and clock counter = 0.
  - Both synchronizer flops = 1.
  - data_out=0x00; valid_out=0; frame_err_out=0; overrun_out=0; busy_out=0.
  - Reset mid-frame aborts the frame with no valid or error output.
- Synchronizer: rx_in passes through 2 flops to give rx_s. All decisions use rx_s only.
- IDLE:
  - rx_s=0 -> START, with clock counter=0.
  - Otherwise stay in IDLE.
- START:
  - Clock counter increments each cycle.
  - When counter==HALF_BIT:
    - rx_s=0 -> DATA, counter=0, bit index=0.
    - rx_s=1 -> IDLE. This is glitch rejection: no output of any kind.
- DATA:
  - At counter==CLKS_PER_BIT-1, sample rx_s into shift bit[index] (LSB first), counter=0, index+1.
  - After the sample with index 7 -> STOP.
- STOP:
  - At counter==CLKS_PER_BIT-1, sample rx_s.
  - rx_s=1:
    - Next cycle: data_out=shifted byte, valid_out=1.
    - State -> IDLE.
  - rx_s=0:
    - Next cycle: frame_err_out=1 for one cycle; data_out and valid_out unchanged.
    - State -> WAIT_HIGH.
- WAIT_HIGH: stay until rx_s=1, then -> IDLE. This prevents a break condition from re-triggering reception.
- Timing:
  - Every sample point falls at mid-bit.
  - valid_out rises 9*CLKS_PER_BIT+HALF_BIT+4 clocks after the rx_in falling edge (1352 for the default).
  - Benches check this with a ±2 clock tolerance.
- Handshake:
  - ack_in=1 while valid_out=1 -> valid_out=0 the next cycle.
  - ack_in while valid_out=0 is ignored.
  - data_out holds its value until the next good byte.
- Byte completes while valid_out=1 and ack_in=0:
  - data_out is overwritten.
  - valid_out stays 1.
  - overrun_out pulses for 1 cycle.
- Byte completes in the same cycle as ack_in=1:
  - The new byte loads and valid_out stays 1.
  - No overrun.
- Back-to-back frames: IDLE re-arms as soon as the stop sample is taken, so a start bit immediately after the stop bit is received correctly.
- busy_out is 1 in START, DATA, STOP and WAIT_HIGH.

Test Plan:
- Send 0xA5 at 142 clk/bit, then ack 10 cycles later -> data_out=0xA5; valid_out high within 1352±2 clocks of the edge; valid_out low the cycle after ack; frame_err_out and overrun_out stay 0.
- rx_in low for 30 clocks, then high -> state back to IDLE after HALF_BIT; busy_out high for about 71 clocks only; valid_out never asserted.
- Send 0x3C with the stop bit forced low, held low 400 clocks, then high, then send 0x81 -> frame_err_out single pulse; no valid for 0x3C; busy_out high through the low period; 0x81 received correctly.
- Send 0x11 then 0x22 with no ack -> overrun_out one pulse at the second completion; data_out=0x22; valid_out=1.
- Send 0x00 and 0xFF back-to-back with zero idle bits, acking each on arrival -> both bytes received correctly; no errors.
- Assert rst_in mid-DATA of 0x5A, release, then send 0xC3 -> outputs all 0 during reset; no byte for 0x5A; 0xC3 received correctly.
